// File: rtl/datapath_pkg.sv
// Shared datapath definitions for the writeback path: default sizes,
// writeback record types and the modular index helper used by the arbiters.
package datapath_pkg;

   localparam int NUM_FU = 3;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam int TAG_W  = 2;

   typedef struct packed {
      logic [REG_W-1:0]  sel;
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } wb_req_t;

   typedef struct packed {
      logic                      write;
      logic                      clear;
      logic [REG_W-1:0]          sel;
      logic [DATA_W-1:0]         data;
      logic [TAG_W-1:0]          tag;
      logic [$clog2(NUM_FU)-1:0] fu;
   } wb_out_t;

   // (base + off) mod n; callers keep base < n so the sum never overflows
   function automatic int wrap_add(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin request picker: first set request at or above ptr, wrapping,
// returned as a one-hot grant plus its index.
module rr_arbiter
   import datapath_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx,
   output logic                 valid
);

   always_comb begin
      int j;
      int hit;
      grant = '0;
      valid = 1'b0;
      hit   = 0;
      for (int k = 0; k < N; k++) begin
         j = wrap_add(int'(ptr), k, N);
         if (!valid && req[j]) begin
            valid    = 1'b1;
            grant[j] = 1'b1;
            hit      = j;
         end
      end
      idx = hit[$clog2(N)-1:0];
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding buffer per functional unit, round-robin
// writeback, WAW-safe busy clear. Optional stall counters: WB_STALL_CNT_EN.
module wb_arbiter #(
   parameter int NUM_FU = datapath_pkg::NUM_FU,
   parameter int REG_W  = datapath_pkg::REG_W,
   parameter int DATA_W = datapath_pkg::DATA_W,
   parameter int TAG_W  = datapath_pkg::TAG_W
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [NUM_FU-1:0]         fu_valid,
   output logic [NUM_FU-1:0]         fu_ready,
   input  logic [NUM_FU*REG_W-1:0]   fu_sel,
   input  logic [NUM_FU*DATA_W-1:0]  fu_data,
   input  logic [NUM_FU*TAG_W-1:0]   fu_tag,
   input  logic                      flush,
   input  logic [TAG_W-1:0]          rst_cur_tag,
   output logic                      wb_write,
   output logic                      wb_clear,
   output logic [REG_W-1:0]          wb_sel,
   output logic [DATA_W-1:0]         wb_data,
   output logic [TAG_W-1:0]          wb_tag,
   output logic [$clog2(NUM_FU)-1:0] wb_fu
`ifdef WB_STALL_CNT_EN
   ,
   output logic [NUM_FU*16-1:0]      stall_cnt
`endif
);

   localparam int PW = $clog2(NUM_FU);

   logic [NUM_FU-1:0] full_q, full_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [REG_W-1:0]  sel_q  [NUM_FU];
   logic [REG_W-1:0]  sel_d  [NUM_FU];
   logic [DATA_W-1:0] data_q [NUM_FU];
   logic [DATA_W-1:0] data_d [NUM_FU];
   logic [TAG_W-1:0]  tag_q  [NUM_FU];
   logic [TAG_W-1:0]  tag_d  [NUM_FU];

   logic [NUM_FU-1:0] grant;
   logic [PW-1:0]     grant_idx;
   logic              grant_valid;

   rr_arbiter #(.N(NUM_FU)) u_rr (
      .req   (full_q),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .idx   (grant_idx),
      .valid (grant_valid)
   );

   // a buffer being drained this cycle can be refilled on the same edge
   assign fu_ready = flush ? '0 : (~full_q | grant);

   assign wb_write = grant_valid;
   assign wb_sel   = grant_valid ? sel_q[grant_idx]  : '0;
   assign wb_data  = grant_valid ? data_q[grant_idx] : '0;
   assign wb_tag   = grant_valid ? tag_q[grant_idx]  : '0;
   assign wb_fu    = grant_valid ? grant_idx         : '0;
   assign wb_clear = grant_valid && (tag_q[grant_idx] == rst_cur_tag);

   always_comb begin
      full_d   = full_q;
      rr_ptr_d = rr_ptr_q;
      for (int i = 0; i < NUM_FU; i++) begin
         sel_d[i]  = sel_q[i];
         data_d[i] = data_q[i];
         tag_d[i]  = tag_q[i];
         if (grant[i]) full_d[i] = 1'b0;
         if (fu_valid[i] && fu_ready[i]) begin
            full_d[i] = 1'b1;
            sel_d[i]  = fu_sel[i*REG_W +: REG_W];
            data_d[i] = fu_data[i*DATA_W +: DATA_W];
            tag_d[i]  = fu_tag[i*TAG_W +: TAG_W];
         end
      end
      if (grant_valid)
         rr_ptr_d = PW'(datapath_pkg::wrap_add(int'(grant_idx), 1, NUM_FU));
      if (flush) begin
         full_d   = '0;
         rr_ptr_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         full_q   <= '0;
         rr_ptr_q <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            sel_q[i]  <= '0;
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         full_q   <= full_d;
         rr_ptr_q <= rr_ptr_d;
         for (int i = 0; i < NUM_FU; i++) begin
            sel_q[i]  <= sel_d[i];
            data_q[i] <= data_d[i];
            tag_q[i]  <= tag_d[i];
         end
      end
   end

`ifdef WB_STALL_CNT_EN
   logic [15:0] stall_q [NUM_FU];
   logic [15:0] stall_d [NUM_FU];

   // counts cycles a result sits buffered while another FU wins the port
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         stall_d[i] = stall_q[i];
         if (flush)
            stall_d[i] = '0;
         else if (full_q[i] && !grant[i] && (stall_q[i] != 16'hFFFF))
            stall_d[i] = stall_q[i] + 16'd1;
         stall_cnt[i*16 +: 16] = stall_q[i];
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NUM_FU; i++) stall_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) stall_q[i] <= stall_d[i];
      end
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a table of per-cycle vectors plus short
// hand-written sequences for refill, mid-operation reset and stall counting.
module tb_wb_arbiter;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        nRST;
   logic [2:0]  fu_valid;
   logic [2:0]  fu_ready;
   logic [14:0] fu_sel;
   logic [95:0] fu_data;
   logic [5:0]  fu_tag;
   logic        flush;
   logic [1:0]  rst_cur_tag;
   logic        wb_write;
   logic        wb_clear;
   logic [4:0]  wb_sel;
   logic [31:0] wb_data;
   logic [1:0]  wb_tag;
   logic [1:0]  wb_fu;
`ifdef WB_STALL_CNT_EN
   logic [47:0] stall_cnt;
`endif

   int nVec = 0;
   int nErr = 0;

   wb_arbiter #(.NUM_FU(3), .REG_W(5), .DATA_W(32), .TAG_W(2)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .fu_valid    (fu_valid),
      .fu_ready    (fu_ready),
      .fu_sel      (fu_sel),
      .fu_data     (fu_data),
      .fu_tag      (fu_tag),
      .flush       (flush),
      .rst_cur_tag (rst_cur_tag),
      .wb_write    (wb_write),
      .wb_clear    (wb_clear),
      .wb_sel      (wb_sel),
      .wb_data     (wb_data),
      .wb_tag      (wb_tag),
      .wb_fu       (wb_fu)
`ifdef WB_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   typedef struct packed {
      logic [2:0] valid;
      logic       flush;
      logic [1:0] cur;
      logic       exp_write;
      logic       exp_clear;
      logic [1:0] exp_fu;
      logic [2:0] exp_ready;
   } vec_t;

   // fixed per-FU payload used by the table
   function automatic logic [4:0] selOf(input logic [1:0] i);
      case (i)
         2'd0: selOf = 5'd7;
         2'd1: selOf = 5'd5;
         default: selOf = 5'd0;
      endcase
   endfunction

   function automatic logic [31:0] dataOf(input logic [1:0] i);
      case (i)
         2'd0: dataOf = 32'h0000_0A0A;
         2'd1: dataOf = 32'hDEAD_BEEF;
         default: dataOf = 32'hC0DE_0002;
      endcase
   endfunction

   function automatic logic [1:0] tagOf(input logic [1:0] i);
      case (i)
         2'd0: tagOf = 2'd1;
         2'd1: tagOf = 2'd2;
         default: tagOf = 2'd3;
      endcase
   endfunction

   function automatic vec_t mk(input logic [2:0] v, input logic f, input logic [1:0] c,
                               input logic w, input logic cl, input logic [1:0] fu,
                               input logic [2:0] r);
      vec_t t;
      t.valid = v; t.flush = f; t.cur = c;
      t.exp_write = w; t.exp_clear = cl; t.exp_fu = fu; t.exp_ready = r;
      return t;
   endfunction

   task automatic drivePayload();
      fu_sel  = {selOf(2'd2), selOf(2'd1), selOf(2'd0)};
      fu_data = {dataOf(2'd2), dataOf(2'd1), dataOf(2'd0)};
      fu_tag  = {tagOf(2'd2), tagOf(2'd1), tagOf(2'd0)};
   endtask

   task automatic checkOutput(input string name, input logic w, input logic c,
                              input logic [4:0] s, input logic [31:0] d,
                              input logic [1:0] t, input logic [1:0] f,
                              input logic [2:0] r);
      nVec++;
      if ({wb_write, wb_clear, wb_sel, wb_data, wb_tag, wb_fu, fu_ready} !== {w, c, s, d, t, f, r}) begin
         nErr++;
         $display("[TB] FAIL %s: got write=%0b clear=%0b sel=%0d data=%h tag=%0d fu=%0d ready=%b, expected write=%0b clear=%0b sel=%0d data=%h tag=%0d fu=%0d ready=%b",
                  name, wb_write, wb_clear, wb_sel, wb_data, wb_tag, wb_fu, fu_ready,
                  w, c, s, d, t, f, r);
      end
   endtask

`ifdef WB_STALL_CNT_EN
   task automatic checkStall(input string name, input logic [47:0] e);
      nVec++;
      if (stall_cnt !== e) begin
         nErr++;
         $display("[TB] FAIL %s: got stall_cnt=%h, expected %h", name, stall_cnt, e);
      end
   endtask
`endif

   task automatic applyStimulus(input vec_t v, input int n);
      fu_valid    = v.valid;
      flush       = v.flush;
      rst_cur_tag = v.cur;
      @(negedge CLK);
      if (v.exp_write)
         checkOutput($sformatf("vec%0d", n), 1'b1, v.exp_clear, selOf(v.exp_fu),
                     dataOf(v.exp_fu), tagOf(v.exp_fu), v.exp_fu, v.exp_ready);
      else
         checkOutput($sformatf("vec%0d", n), 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, v.exp_ready);
      @(posedge CLK);
      #1;
   endtask

   vec_t tbl [22];

   initial begin
      // inputs, flush, cur_tag | write, clear, fu, ready
      tbl[0]  = mk(3'b010, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 3'b111);
      tbl[1]  = mk(3'b000, 1'b0, 2'd2, 1'b1, 1'b1, 2'd1, 3'b111);
      tbl[2]  = mk(3'b000, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 3'b111);
      tbl[3]  = mk(3'b001, 1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 3'b111);
      tbl[4]  = mk(3'b000, 1'b0, 2'd3, 1'b1, 1'b0, 2'd0, 3'b111);
      tbl[5]  = mk(3'b000, 1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 3'b111);
      tbl[6]  = mk(3'b101, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 3'b111);
      tbl[7]  = mk(3'b001, 1'b0, 2'd3, 1'b1, 1'b1, 2'd2, 3'b110);
      tbl[8]  = mk(3'b001, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 3'b111);
      tbl[9]  = mk(3'b000, 1'b0, 2'd1, 1'b1, 1'b1, 2'd0, 3'b111);
      tbl[10] = mk(3'b000, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 3'b000);
      tbl[11] = mk(3'b111, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 3'b111);
      tbl[12] = mk(3'b111, 1'b0, 2'd1, 1'b1, 1'b1, 2'd0, 3'b001);
      tbl[13] = mk(3'b111, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, 3'b010);
      tbl[14] = mk(3'b111, 1'b0, 2'd3, 1'b1, 1'b1, 2'd2, 3'b100);
      tbl[15] = mk(3'b111, 1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 3'b001);
      tbl[16] = mk(3'b111, 1'b0, 2'd2, 1'b1, 1'b1, 2'd1, 3'b010);
      tbl[17] = mk(3'b111, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 3'b100);
      tbl[18] = mk(3'b000, 1'b0, 2'd1, 1'b1, 1'b1, 2'd0, 3'b001);
      tbl[19] = mk(3'b111, 1'b1, 2'd2, 1'b1, 1'b1, 2'd1, 3'b000);
      tbl[20] = mk(3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 3'b111);
      tbl[21] = mk(3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 3'b111);

      // reset held across an edge with every FU offering a result
      nRST = 1'b0; fu_valid = 3'b111; flush = 1'b0; rst_cur_tag = 2'd0;
      drivePayload();
      @(negedge CLK);
      checkOutput("reset_a", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 3'b111);
      @(posedge CLK); #1;
      @(negedge CLK);
      checkOutput("reset_b", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 3'b111);
      fu_valid = 3'b000;
      nRST = 1'b1;
      @(posedge CLK); #1;

      for (int n = 0; n < 22; n++) applyStimulus(tbl[n], n);
`ifdef WB_STALL_CNT_EN
      checkStall("stall_after_flush", 48'd0);
`endif

      // granted buffer refilled on its retire edge carries the new result
      fu_valid = 3'b010; rst_cur_tag = 2'd2;
      @(negedge CLK);
      checkOutput("refill_load", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 3'b111);
      @(posedge CLK); #1;
      fu_sel[9:5] = 5'd9; fu_data[63:32] = 32'h1234_5678; fu_tag[3:2] = 2'd0;
      rst_cur_tag = 2'd0;
      @(negedge CLK);
      checkOutput("refill_old", 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 2'd2, 2'd1, 3'b111);
      @(posedge CLK); #1;
      fu_valid = 3'b000;
      @(negedge CLK);
      checkOutput("refill_new", 1'b1, 1'b1, 5'd9, 32'h1234_5678, 2'd0, 2'd1, 3'b111);
      @(posedge CLK); #1;
      @(negedge CLK);
      checkOutput("refill_idle", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 3'b111);
      @(posedge CLK); #1;
      drivePayload();

      // reset between edges drops a buffered result with no writeback
      fu_valid = 3'b100;
      @(posedge CLK); #1;
      fu_valid = 3'b000;
      #2 nRST = 1'b0;
      #1 checkOutput("midreset_async", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 3'b111);
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      checkOutput("midreset_after", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 3'b111);
      @(posedge CLK); #1;

      // three buffers drained in order, then flushed
      fu_valid = 3'b111; rst_cur_tag = 2'd0;
      @(negedge CLK);
      checkOutput("drain_load", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 3'b111);
      @(posedge CLK); #1;
      fu_valid = 3'b000;
      @(negedge CLK);
      checkOutput("drain_fu0", 1'b1, 1'b0, 5'd7, 32'h0000_0A0A, 2'd1, 2'd0, 3'b001);
      @(posedge CLK); #1;
      rst_cur_tag = 2'd2;
      @(negedge CLK);
      checkOutput("drain_fu1", 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd2, 2'd1, 3'b011);
      @(posedge CLK); #1;
      rst_cur_tag = 2'd0;
      @(negedge CLK);
      checkOutput("drain_fu2", 1'b1, 1'b0, 5'd0, 32'hC0DE_0002, 2'd3, 2'd2, 3'b111);
      @(posedge CLK); #1;
`ifdef WB_STALL_CNT_EN
      checkStall("stall_drain", {16'd2, 16'd1, 16'd0});
`endif
      flush = 1'b1;
      @(negedge CLK);
      checkOutput("drain_flush", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 3'b000);
      @(posedge CLK); #1;
      flush = 1'b0;
`ifdef WB_STALL_CNT_EN
      checkStall("stall_flushed", 48'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
